// File: rtl/p2s_rr_scheduler_pkg.sv
// Shared definitions for the round-robin parallel-to-serial scheduler.
// Frame length depends on P2S_RR_SCHEDULER_PARITY_EN (adds one even-parity bit).
package p2s_rr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic int frame_len(input int data_w);
`ifdef P2S_RR_SCHEDULER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    // First set bit of valid searching upward from last+1 with wrap; 0 if none set.
    function automatic int rr_next(input logic [15:0] valid, input int last, input int num_req);
        int   idx;
        logic found;
        rr_next = 0;
        found   = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i <= num_req) begin
                idx = (last + i) % num_req;
                if (!found && valid[idx[3:0]]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/p2s_rr_scheduler_shifter.sv
// Loadable MSB-first shift register with registered serial, valid and frame strobes.
// With P2S_RR_SCHEDULER_PARITY_EN an even-parity bit follows the data LSB.
module p2s_shifter
    import p2s_rr_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              serial,
    output logic              valid,
    output logic              sof,
    output logic              eof,
    output logic              done
);

    localparam int FRAME_LEN = frame_len(DATA_W);

    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
`ifdef P2S_RR_SCHEDULER_PARITY_EN
    logic              parity_bit;
`endif

    // bit_cnt holds how many frame bits have been presented so far
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            serial    <= 1'b0;
            valid     <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
`ifdef P2S_RR_SCHEDULER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (load) begin
            shift_reg <= load_data << 1;
            bit_cnt   <= CNT_W'(1);
            serial    <= load_data[DATA_W-1];
            valid     <= 1'b1;
            sof       <= 1'b1;
            eof       <= 1'b0;
`ifdef P2S_RR_SCHEDULER_PARITY_EN
            parity_bit <= ^load_data;
`endif
        end else if (valid) begin
            if (bit_cnt == CNT_W'(FRAME_LEN)) begin
                bit_cnt <= '0;
                serial  <= 1'b0;
                valid   <= 1'b0;
                sof     <= 1'b0;
                eof     <= 1'b0;
            end else begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                shift_reg <= shift_reg << 1;
                sof       <= 1'b0;
                eof       <= (bit_cnt == CNT_W'(FRAME_LEN - 1));
`ifdef P2S_RR_SCHEDULER_PARITY_EN
                serial    <= (bit_cnt == CNT_W'(DATA_W)) ? parity_bit : shift_reg[DATA_W-1];
`else
                serial    <= shift_reg[DATA_W-1];
`endif
            end
        end
    end

    assign done = valid & eof;

endmodule

// File: rtl/p2s_rr_scheduler.sv
// Round-robin arbiter and frame FSM sharing one p2s_shifter among NUM_REQ requesters.
// Optional parity bit per frame via P2S_RR_SCHEDULER_PARITY_EN.
module p2s_rr_scheduler
    import p2s_rr_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       serial_o,
    output logic                       valid_o,
    output logic                       sof_o,
    output logic                       eof_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o
);

    localparam int FRAME_LEN = frame_len(DATA_W);
    localparam int CNT_MAX   = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int GID_W     = $clog2(NUM_REQ);

    logic [1:0]        state;
    logic [GID_W-1:0]  last_grant;
    logic [GID_W-1:0]  winner;
    logic [CNT_W-1:0]  gap_cnt;
    logic              accept;
    logic              shift_done;
    logic [DATA_W-1:0] win_data;

    // Ready is combinational so the handshake completes in the arbitration cycle
    always_comb begin
        winner      = GID_W'(rr_next(16'(req_valid_i), int'(last_grant), NUM_REQ));
        accept      = (state == ST_IDLE) && (|req_valid_i);
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[winner] = 1'b1;
        end
        win_data = req_data_i[winner*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GID_W'(NUM_REQ - 1);
            grant_id_o <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        grant_id_o <= winner;
                        last_grant <= winner;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done) begin
                        if (GAP_CYCLES > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= CNT_W'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt >= CNT_W'(GAP_CYCLES)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

    p2s_shifter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (win_data),
        .serial    (serial_o),
        .valid     (valid_o),
        .sof       (sof_o),
        .eof       (eof_o),
        .done      (shift_done)
    );

endmodule
